// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator (640x480@60 by default, fully parameterised).
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Half-open window test: lo <= pos < hi
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             frame_start_s;

    logic             hsync_r;
    logic             vsync_r;
    logic             video_on_r;
    logic [CNT_W-1:0] pixel_x_r;
    logic [CNT_W-1:0] pixel_y_r;
    logic             frame_start_r;

    // Next counter position; line and frame wrap resolve in one step
    always_comb begin
        h_next_s = h_cnt_r;
        v_next_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = CNT_ZERO;
            if (v_cnt_r == V_LAST) begin
                v_next_s = CNT_ZERO;
            end else begin
                v_next_s = v_cnt_r + CNT_ONE;
            end
        end else begin
            h_next_s = h_cnt_r + CNT_ONE;
            v_next_s = v_cnt_r;
        end
    end

    // Frame start decode on the upcoming position
    always_comb begin
        frame_start_s = 1'b0;
        if ((h_next_s == CNT_ZERO) && (v_next_s == CNT_ZERO)) begin
            frame_start_s = 1'b1;
        end else begin
            frame_start_s = 1'b0;
        end
    end

    // Counters and decoded outputs share one edge so outputs describe the live position
    always_ff @(posedge clk_in) begin
        if (rst) begin
            h_cnt_r       <= H_LAST;
            v_cnt_r       <= V_LAST;
            pixel_x_r     <= CNT_ZERO;
            pixel_y_r     <= CNT_ZERO;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
        end else begin
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            pixel_x_r     <= h_next_s;
            pixel_y_r     <= v_next_s;
            video_on_r    <= (h_next_s < H_VIS_END) && (v_next_s < V_VIS_END);
            frame_start_r <= frame_start_s;
            hsync_r       <= in_window(h_next_s, HS_START, HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_r       <= in_window(v_next_s, VS_START, VS_END) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign pixel_x     = pixel_x_r;
    assign pixel_y     = pixel_y_r;
    assign frame_start = frame_start_r;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_r;

    // Reset value 0xFF makes the first frame after reset read 0x00
    always_ff @(posedge clk_in) begin
        if (rst) begin
            frame_cnt_r <= 8'hFF;
        end else if (frame_start_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule
